// File: rtl/dram_bank_pkg.sv
// Shared types for the single-bank open-page DRAM responder: state encoding,
// request classification and default port widths.
package dram_bank_pkg;

    localparam int DEF_ADDR_WIDTH = 64;
    localparam int DEF_WORD_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRECHARGE = 2'd1,
        ST_ACTIVATE  = 2'd2,
        ST_ACCESS    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CLS_HIT      = 2'd0,
        CLS_EMPTY    = 2'd1,
        CLS_CONFLICT = 2'd2
    } row_class_e;

    function automatic row_class_e classify(input logic open_valid, input logic row_match);
        row_class_e cls;
        if (!open_valid) begin
            cls = CLS_EMPTY;
        end else if (row_match) begin
            cls = CLS_HIT;
        end else begin
            cls = CLS_CONFLICT;
        end
        return cls;
    endfunction

endpackage

// File: rtl/dram_bank_if.sv
// Memory port bundle between an upstream requester (master) and the bank (slave).
interface dram_bank_if
    import dram_bank_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
) ();

    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] din;
    logic [WORD_WIDTH-1:0] dout;
    logic                  re;
    logic                  we;
    logic                  ready;

    modport master (output addr, output din, output re, output we, input dout, input ready);
    modport slave  (input addr, input din, input re, input we, output dout, output ready);

endinterface

// File: rtl/dram_bank_array.sv
// Single-port synchronous storage; the read register doubles as the bank's
// dout, so it is the only part of the array that is reset.
module dram_bank_array #(
    parameter int DEPTH_BITS = 10,
    parameter int WORD_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [DEPTH_BITS-1:0] addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem_r [0:(2**DEPTH_BITS)-1];
    logic [WORD_WIDTH-1:0] rdata_r;

    // Storage write port, contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read; holds its value until the next read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= {WORD_WIDTH{1'b0}};
        end else if (rd_en) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dram_bank.sv
// Single-bank DRAM responder with an open-page timing model
// (precharge / activate / access phases) and hit/empty/conflict statistics.
module dram_bank
    import dram_bank_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int DEPTH_BITS = 10,
    parameter int COL_BITS   = 4,
    parameter int CAS_CYCLES = 2,
    parameter int RCD_CYCLES = 3,
    parameter int RP_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    dram_bank_if.slave  bus,
    output logic [31:0] hit_count,
    output logic [31:0] empty_count,
    output logic [31:0] conflict_count
);

    localparam logic [1:0] S_IDLE      = ST_IDLE;
    localparam logic [1:0] S_PRECHARGE = ST_PRECHARGE;
    localparam logic [1:0] S_ACTIVATE  = ST_ACTIVATE;
    localparam logic [1:0] S_ACCESS    = ST_ACCESS;

    localparam int MAX_CYC = (CAS_CYCLES > RCD_CYCLES) ?
                             ((CAS_CYCLES > RP_CYCLES) ? CAS_CYCLES : RP_CYCLES) :
                             ((RCD_CYCLES > RP_CYCLES) ? RCD_CYCLES : RP_CYCLES);
    localparam int TW    = $clog2(MAX_CYC + 1);
    localparam int ROW_W = DEPTH_BITS - COL_BITS;

    logic [1:0]            state_r;
    logic [TW-1:0]         timer_r;
    logic                  ready_r;
    logic                  open_valid_r;
    logic [ROW_W-1:0]      open_row_r;
    logic [DEPTH_BITS-1:0] req_addr_r;
    logic [WORD_WIDTH-1:0] req_din_r;
    logic                  req_write_r;
    logic [31:0]           hit_r;
    logic [31:0]           empty_r;
    logic [31:0]           conflict_r;

    logic                  accept_s;
    logic                  done_s;
    row_class_e            class_s;
    logic [WORD_WIDTH-1:0] rdata_s;
    logic                  unused_addr_s;

    assign accept_s      = ready_r & (bus.re | bus.we);
    assign unused_addr_s = ^bus.addr[ADDR_WIDTH-1:DEPTH_BITS];

    // Request classification against the open row, and the completion strobe
    always_comb begin
        class_s = classify(open_valid_r,
                           open_row_r == bus.addr[DEPTH_BITS-1:COL_BITS]);
        if ((state_r == S_ACCESS) && (timer_r == {TW{1'b0}})) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // Phase FSM with down-counter timer and open-row tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            timer_r      <= {TW{1'b0}};
            ready_r      <= 1'b1;
            open_valid_r <= 1'b0;
            open_row_r   <= {ROW_W{1'b0}};
            req_addr_r   <= {DEPTH_BITS{1'b0}};
            req_din_r    <= {WORD_WIDTH{1'b0}};
            req_write_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        ready_r     <= 1'b0;
                        req_addr_r  <= bus.addr[DEPTH_BITS-1:0];
                        req_din_r   <= bus.din;
                        req_write_r <= bus.we;
                        case (class_s)
                            CLS_HIT: begin
                                state_r <= S_ACCESS;
                                timer_r <= TW'(CAS_CYCLES - 1);
                            end
                            CLS_EMPTY: begin
                                state_r <= S_ACTIVATE;
                                timer_r <= TW'(RCD_CYCLES - 1);
                            end
                            default: begin
                                state_r <= S_PRECHARGE;
                                timer_r <= TW'(RP_CYCLES - 1);
                            end
                        endcase
                    end
                end
                S_PRECHARGE: begin
                    if (timer_r == {TW{1'b0}}) begin
                        state_r      <= S_ACTIVATE;
                        timer_r      <= TW'(RCD_CYCLES - 1);
                        open_valid_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r - 1'b1;
                    end
                end
                S_ACTIVATE: begin
                    if (timer_r == {TW{1'b0}}) begin
                        state_r      <= S_ACCESS;
                        timer_r      <= TW'(CAS_CYCLES - 1);
                        open_valid_r <= 1'b1;
                        open_row_r   <= req_addr_r[DEPTH_BITS-1:COL_BITS];
                    end else begin
                        timer_r <= timer_r - 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (timer_r == {TW{1'b0}}) begin
                        state_r <= S_IDLE;
                        ready_r <= 1'b1;
                    end else begin
                        timer_r <= timer_r - 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Statistics, bumped on the accept edge by request class
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_r      <= 32'd0;
            empty_r    <= 32'd0;
            conflict_r <= 32'd0;
        end else if (accept_s) begin
            case (class_s)
                CLS_HIT:      hit_r      <= hit_r + 32'd1;
                CLS_EMPTY:    empty_r    <= empty_r + 32'd1;
                CLS_CONFLICT: conflict_r <= conflict_r + 32'd1;
                default:      hit_r      <= hit_r;
            endcase
        end
    end

    dram_bank_array #(
        .DEPTH_BITS (DEPTH_BITS),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .rd_en (done_s & ~req_write_r),
        .wr_en (done_s & req_write_r),
        .addr  (req_addr_r),
        .wdata (req_din_r),
        .rdata (rdata_s)
    );

    assign bus.dout       = rdata_s;
    assign bus.ready      = ready_r;
    assign hit_count      = hit_r;
    assign empty_count    = empty_r;
    assign conflict_count = conflict_r;

endmodule

// File: tb/tb_dram_bank.sv
// Directed bench for dram_bank with default timing (CAS=2, RCD=3, RP=4).
module tb_dram_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] hit_count;
    logic [31:0] empty_count;
    logic [31:0] conflict_count;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_hit      = 32'd0;
    logic [31:0] exp_empty    = 32'd0;
    logic [31:0] exp_conflict = 32'd0;

    dram_bank_if bus ();

    dram_bank dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave),
        .hit_count      (hit_count),
        .empty_count    (empty_count),
        .conflict_count (conflict_count)
    );

    always #5 clk = ~clk;

    // Issue one request, then count negedge samples with ready low (bounded)
    task automatic issue(input logic rd, input logic wr, input logic [63:0] a,
                         input logic [63:0] d, output int lat);
        @(negedge clk);
        bus.re = rd; bus.we = wr; bus.addr = a; bus.din = d;
        @(posedge clk); #1;
        bus.re = 1'b0; bus.we = 1'b0;
        lat = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && lat < 40) begin
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.re = 1'b0; bus.we = 1'b0; bus.addr = 64'd0; bus.din = 64'd0;
        #12;
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
        total++; if (bus.dout !== 64'd0) begin bad++; $display("FAIL reset_dout: got %h want 0", bus.dout); end
        total++; if ({hit_count, empty_count, conflict_count} !== 96'd0) begin bad++;
            $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", hit_count, empty_count, conflict_count); end
        @(negedge clk); rst = 1'b1;
        // Start an empty-row write, then pull reset while it is activating
        @(negedge clk);
        bus.we = 1'b1; bus.addr = 64'd500; bus.din = 64'hdead;
        @(posedge clk); #1;
        bus.we = 1'b0;
        @(negedge clk);
        total++; if (bus.ready !== 1'b0 || empty_count !== 32'd1) begin bad++;
            $display("FAIL mid_activate_busy: got ready=%b empty=%0d want ready=0 empty=1", bus.ready, empty_count); end
        rst = 1'b0; #1;
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", bus.ready); end
        total++; if (bus.dout !== 64'd0) begin bad++; $display("FAIL abort_dout: got %h want 0", bus.dout); end
        total++; if ({hit_count, empty_count, conflict_count} !== 96'd0) begin bad++;
            $display("FAIL abort_counters: got %0d/%0d/%0d want 0/0/0", hit_count, empty_count, conflict_count); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_empty_hit();
        int lat;
        issue(1'b0, 1'b1, 64'd1, 64'h0123456789abcdef, lat);
        exp_empty++;
        total++; if (lat !== 5) begin bad++; $display("FAIL empty_write_latency: got %0d want 5", lat); end
        total++; if (empty_count !== exp_empty) begin bad++; $display("FAIL empty_count: got %0d want %0d", empty_count, exp_empty); end
        issue(1'b1, 1'b0, 64'd1, 64'd0, lat);
        exp_hit++;
        total++; if (lat !== 2) begin bad++; $display("FAIL hit_read_latency: got %0d want 2", lat); end
        total++; if (bus.dout !== 64'h0123456789abcdef) begin bad++; $display("FAIL hit_read_data: got %h want 0123456789abcdef", bus.dout); end
        total++; if (hit_count !== exp_hit) begin bad++; $display("FAIL hit_count: got %0d want %0d", hit_count, exp_hit); end
    endtask

    task automatic test_conflict();
        int lat;
        issue(1'b0, 1'b1, 64'd257, 64'd123, lat);
        exp_conflict++;
        total++; if (lat !== 9) begin bad++; $display("FAIL conflict_write_latency: got %0d want 9", lat); end
        total++; if (conflict_count !== exp_conflict) begin bad++; $display("FAIL conflict_count_1: got %0d want %0d", conflict_count, exp_conflict); end
        issue(1'b1, 1'b0, 64'd257, 64'd0, lat);
        exp_hit++;
        total++; if (lat !== 2) begin bad++; $display("FAIL row16_hit_latency: got %0d want 2", lat); end
        total++; if (bus.dout !== 64'd123) begin bad++; $display("FAIL row16_read_data: got %0d want 123", bus.dout); end
        issue(1'b1, 1'b0, 64'd1, 64'd0, lat);
        exp_conflict++;
        total++; if (lat !== 9) begin bad++; $display("FAIL conflict_read_latency: got %0d want 9", lat); end
        total++; if (bus.dout !== 64'h0123456789abcdef) begin bad++; $display("FAIL conflict_read_data: got %h want 0123456789abcdef", bus.dout); end
        total++; if ({hit_count, empty_count, conflict_count} !== {exp_hit, exp_empty, exp_conflict}) begin bad++;
            $display("FAIL counters_after_conflict: got %0d/%0d/%0d want %0d/%0d/%0d",
                     hit_count, empty_count, conflict_count, exp_hit, exp_empty, exp_conflict); end
    endtask

    task automatic test_wrap();
        int lat;
        issue(1'b0, 1'b1, 64'd1025, 64'd5, lat);
        exp_hit++;
        total++; if (lat !== 2) begin bad++; $display("FAIL wrap_write_latency: got %0d want 2", lat); end
        issue(1'b1, 1'b0, 64'd1, 64'd0, lat);
        exp_hit++;
        total++; if (lat !== 2) begin bad++; $display("FAIL wrap_read_latency: got %0d want 2", lat); end
        total++; if (bus.dout !== 64'd5) begin bad++; $display("FAIL wrap_read_data: got %0d want 5", bus.dout); end
    endtask

    task automatic test_simultaneous_ignored();
        int lat;
        issue(1'b1, 1'b1, 64'd2, 64'd77, lat);
        exp_hit++;
        total++; if (bus.dout !== 64'd5) begin bad++; $display("FAIL rw_keeps_dout: got %0d want 5", bus.dout); end
        issue(1'b1, 1'b0, 64'd2, 64'd0, lat);
        exp_hit++;
        total++; if (bus.dout !== 64'd77) begin bad++; $display("FAIL rw_was_write: got %0d want 77", bus.dout); end
        // Read addr 257 (conflict), with a stray re pulse while busy
        @(negedge clk);
        bus.re = 1'b1; bus.addr = 64'd257;
        @(posedge clk); #1;
        bus.re = 1'b0;
        exp_conflict++;
        @(negedge clk);
        bus.re = 1'b1; bus.addr = 64'd3;
        @(posedge clk); #1;
        bus.re = 1'b0;
        lat = 0;
        while (bus.ready !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        repeat (3) @(negedge clk);
        total++; if (bus.ready !== 1'b1 || bus.dout !== 64'd123) begin bad++;
            $display("FAIL ignored_re_state: got ready=%b dout=%0d want ready=1 dout=123", bus.ready, bus.dout); end
        total++; if ({hit_count, empty_count, conflict_count} !== {exp_hit, exp_empty, exp_conflict}) begin bad++;
            $display("FAIL ignored_re_counters: got %0d/%0d/%0d want %0d/%0d/%0d",
                     hit_count, empty_count, conflict_count, exp_hit, exp_empty, exp_conflict); end
    endtask

    task automatic test_back_to_back();
        int lat;
        // Open row is 16 here; first read of addr 1 conflicts, second hits
        @(negedge clk);
        bus.re = 1'b1; bus.addr = 64'd1;
        @(posedge clk); #1;
        exp_conflict++;
        lat = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        total++; if (lat !== 9) begin bad++; $display("FAIL b2b_first_latency: got %0d want 9", lat); end
        @(posedge clk); #1;
        bus.re = 1'b0;
        exp_hit++;
        @(negedge clk);
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL b2b_no_gap: got ready=%b want 0", bus.ready); end
        lat = 1;
        @(negedge clk);
        while (bus.ready !== 1'b1 && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        total++; if (lat !== 2) begin bad++; $display("FAIL b2b_second_latency: got %0d want 2", lat); end
        total++; if (bus.dout !== 64'd5) begin bad++; $display("FAIL b2b_data: got %0d want 5", bus.dout); end
        total++; if ({hit_count, empty_count, conflict_count} !== {exp_hit, exp_empty, exp_conflict}) begin bad++;
            $display("FAIL b2b_counters: got %0d/%0d/%0d want %0d/%0d/%0d",
                     hit_count, empty_count, conflict_count, exp_hit, exp_empty, exp_conflict); end
    endtask

    initial begin
        test_reset();
        test_empty_hit();
        test_conflict();
        test_wrap();
        test_simultaneous_ignored();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_bank.md
Name: dram_bank

Overview:
- Synthesizable single-bank DRAM-style memory responder for the 64-bit memory port (addr/din/dout/re/we/ready).
- Sits at the bottom of a hierarchy: cache, spm, split or combine upstream; no downstream port.
- Open-page timing model: latency depends on whether the request hits the open row, finds no open row, or conflicts with another open row.
- Three statistics counters expose hit, empty and conflict counts.

Parameters:
ADDR_WIDTH, 64, width of addr.
WORD_WIDTH, 64, width of din/dout.
DEPTH_BITS, 10, log2 of the number of stored words; addr bits above this are ignored (wrap).
COL_BITS, 4, log2 of words per row; row = addr[DEPTH_BITS-1:COL_BITS], column = addr[COL_BITS-1:0].
CAS_CYCLES, 2, access phase length; must be >= 1.
RCD_CYCLES, 3, activate phase length; must be >= 1.
RP_CYCLES, 4, precharge phase length; must be >= 1.

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
addr  in  ADDR_WIDTH  word address
din  in  WORD_WIDTH  write data
dout  out  WORD_WIDTH  read data
re  in  1  read request
we  in  1  write request
ready  out  1  idle, and dout valid for the last read
hit_count  out  32  requests that hit the open row
empty_count  out  32  requests issued with no row open
conflict_count  out  32  requests that found a different row open

Behaviour:
- Reset: rst low asynchronously forces the following:
  - state IDLE, ready=1, dout=0;
  - no row open, all counters 0;
  - storage contents are not cleared.
- Reset during any phase aborts the transaction. A pending write is dropped.
- Accept rule: a request is accepted on a rising edge where ready=1 and (re|we)=1.
  - addr, din and the operation are latched into registers.
  - ready=0 from that edge on.
  - re/we while ready=0 are ignored.
  - we=1 together with re=1 is a write; dout is unchanged.
- States are IDLE, PRECHARGE, ACTIVATE, ACCESS. On accept:
  - Open row equals the request row: ACCESS; hit_count+1.
  - No row open: ACTIVATE; empty_count+1.
  - Different row open: PRECHARGE; conflict_count+1.
- Phase transitions: each phase runs for its parameter number of cycles on a down-counter, then advances.
  - PRECHARGE -> ACTIVATE; the open row is cleared on leaving PRECHARGE.
  - ACTIVATE -> ACCESS; the open row is set to the request row on leaving ACTIVATE.
  - ACCESS -> IDLE.
- Completion, on the final ACCESS edge:
  - Read: dout <= storage[addr mod 2^DEPTH_BITS].
  - Write: storage[addr mod 2^DEPTH_BITS] <= din.
  - ready returns to 1 on the same edge.
- Latency: ready is sampled low for exactly the number of cycles below, then high.
  - Hit: CAS.
  - Empty: RCD+CAS.
  - Conflict: RP+RCD+CAS.
- dout holds its value until the next read completes. Writes never change dout.
- A new request may be accepted on the same edge ready is first sampled high. There is no dead cycle.
- The row stays open after ACCESS (open-page policy). There is no auto-precharge or refresh.
- Counters wrap modulo 2^32. A counter increments on the accept edge.
- The phase counter is wide enough for the largest of the three parameters.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, PRECHARGE, ACTIVATE, ACCESS);
  - the port width defaults (64);
  - a classification enum (HIT, EMPTY, CONFLICT) used by the stats logic.
- One sub-module is natural: dram_bank_array.
  - Single-port synchronous storage of 2^DEPTH_BITS x WORD_WIDTH.
  - Registered read, write enable.
  - No reset on contents.
- The FSM, timer and counters stay in dram_bank.

Test Plan (defaults CAS=2, RCD=3, RP=4):
- Reset, then idle:
  - ready=1, dout=0, all counters 0.
  - Pulse rst low mid-ACTIVATE: ready=1 immediately, dout=0, counters 0.
- Empty-row write then hit read:
  - Write addr 1, data 64'h0123456789abcdef: ready low exactly 5 cycles, empty_count=1.
  - Read addr 1: ready low exactly 2 cycles, dout=64'h0123456789abcdef, hit_count=1.
- Row conflict:
  - Write addr 257, data 123 (row 16 vs row 0): ready low exactly 9 cycles, conflict_count=1.
  - Read addr 257: 2 cycles, dout=123.
  - Read addr 1: 9 cycles, dout=64'h0123456789abcdef, conflict_count=2.
- Wrap-around: write addr 1025, data 5, then read addr 1 -> dout=5. The read is a row hit, 2 cycles.
- Simultaneous and ignored requests:
  - re=1 and we=1 with addr 2, din 77, prior dout=X0: treated as write, dout stays X0.
  - A read of addr 2 returns 77.
  - re pulsed while ready=0: no extra transaction, counters unchanged.
- Back-to-back: hold re=1 with addr 1 across completion -> a second read is accepted on the edge ready rises, with no idle gap, and hit_count increments.
